cache: RTL and testbench
========================

Name: cache

Overview:
- Two-way set-associative, write-back, write-allocate data cache between a core load/store port and a line-granular memory interface.
- The core issues word-addressed read/write requests and gets completion via op_finished.
- Misses evict a victim, writing it back if dirty, then fetch a 128-bit line from memory.

Parameters:
ADDR_WIDTH, 32, address and data word width (index range [`MAX_BIT_POS:0]).
LINE_WIDTH, 128, line width in bits (`CACHE_LINE_WIDTH); 4 words/line, offset = addr[3:0].
NUM_SETS, 16, sets; index = addr[7:4], tag = addr[31:8].

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
read_enable  in  1  read request, held until op_finished seen
write_enable  in  1  write request, held until op_finished seen; wins over read_enable
addr  in  32  request byte address
byte_size  in  2  write size: 00 word, 01 byte, 10 halfword, 11 word
wdata  in  32  write data, right-aligned
rdata  out  32  read data, the aligned word containing addr
op_finished  out  1  request complete
write_back_enable  out  1  dirty-victim write-back request
write_back_data  out  128  victim line
write_back_finished  in  1  memory accepted write-back
load_enable  out  1  line fill request
mem_addr  out  32  line-aligned memory address (victim for write-back, request for load)
ldata  in  128  fill line, word0 in bits [31:0]
load_finished  in  1  ldata valid

Behaviour:
- Storage per way/set: valid, dirty, tag, 128-bit line. One LRU bit per set.
- Reset (async, rst_n=0): valid, dirty and LRU cleared; FSM to IDLE; all outputs 0. Reset mid-operation aborts it with no state kept.
- FSM states: IDLE, LOOKUP, WRITE_BACK, LOAD, DONE.
- IDLE: on read_enable or write_enable, latch addr, wdata, byte_size and op, then go to LOOKUP.
- LOOKUP, hit:
  - Read: rdata <= word addr[3:2].
  - Write: merge per byte_size at byte offset addr[1:0]; set dirty.
  - Update LRU to mark the other way; go to DONE.
  - Hit latency: op_finished rises on the 2nd rising edge after the request is sampled.
- LOOKUP, miss:
  - Victim is the first invalid way (way0 first), else the LRU way.
  - If the victim is valid and dirty, go to WRITE_BACK; otherwise go to LOAD.
- WRITE_BACK: write_back_enable=1; write_back_data = victim line; mem_addr = {victim tag, index, 4'b0}. Hold until write_back_finished, then clear the victim's dirty bit and go to LOAD.
- LOAD: load_enable=1; mem_addr = {addr[31:4], 4'b0}. Hold until load_finished, then write ldata into the victim, set valid=1, dirty=0, update tag, and return to LOOKUP (now a hit; a write merges here).
- DONE: op_finished=1 and rdata held stable until both enables are low, then return to IDLE with op_finished=0. This guarantees one completion per request.
- Write sizes:
  - Byte writes wdata[7:0] to byte addr[1:0].
  - Halfword writes wdata[15:0] to bytes addr[1]*2 .. +1 (addr[0] ignored).
  - Word ignores addr[1:0].
- Requests and addr changes outside IDLE are ignored. write_back_finished and load_finished are ignored outside their states.

Optional Feature:
CACHE_STATS_EN: when defined, adds outputs hit_count[31:0] and miss_count[31:0].
- Both cleared by reset.
- Each LOOKUP that is a first-time hit increments hit_count; each LOOKUP miss increments miss_count. The post-fill re-lookup is not counted.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then write addr 0x0 wdata 0x1234 (word) with ldata=0 -> LOAD with mem_addr 0x0, load_finished; op_finished; no write-back. Then read 0x0 -> rdata 0x00001234, hit latency 2 cycles.
- Fill: read 0x10 with ldata 128'h0000_1010_0000_1C1C_0000_1414_0000_1111 -> rdata 0x1111. Reads 0x14/0x18/0x1C -> 0x1414/0x1C1C/0x1010, all hits with no load_enable.
- Second way: read 0xA000_0000 with ldata 0xAAAA -> 0xAAAA. Read 0x0 -> still 0x1234, no memory traffic.
- Dirty eviction: with set0 holding 0x0 (dirty, LRU) and 0xA000_0000, read 0xB000_0000 -> write_back_enable with mem_addr 0x0 and write_back_data word0 0x1234; after write_back_finished, load of 0xB000_0000 -> rdata = fill word0. A clean-victim miss produces no write_back_enable.
- Byte/halfword write: byte_size 01 at 0x11 wdata 0xAB -> read 0x10 returns 0x0000AB11. byte_size 10 at 0x12 wdata 0xBEEF -> 0xBEEFAB11.
- Handshake/reset: enables held high after op_finished -> op_finished stays 1 with no second op. rst_n low during LOAD -> outputs 0 immediately, and a re-read misses.

Source files
------------

// File: rtl/cache.sv
// Two-way set-associative, write-back, write-allocate data cache.
// Optional build macro CACHE_STATS_EN adds hit_count / miss_count outputs.
module cache #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int NUM_SETS   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_enable,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            byte_size,
  input  logic [ADDR_WIDTH-1:0] wdata,
  output logic [ADDR_WIDTH-1:0] rdata,
  output logic                  op_finished,
  output logic                  write_back_enable,
  output logic [LINE_WIDTH-1:0] write_back_data,
  input  logic                  write_back_finished,
  output logic                  load_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [LINE_WIDTH-1:0] ldata,
  input  logic                  load_finished
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int WSL_W = $clog2(LINE_WIDTH / ADDR_WIDTH);

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITE_BACK, LOAD, DONE} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] wdata;
    logic [1:0]            size;
    logic                  wr;
  } req_t;

  state_t                state_q, state_d;
  req_t                  req_q, req_d;
  logic                  victim_q, victim_d;
  logic                  refill_q, refill_d;
  logic [ADDR_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0][NUM_SETS-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [NUM_SETS-1:0]      lru_q, lru_d;   // bit = way to evict next
  logic [1:0][NUM_SETS-1:0][TAG_W-1:0]      tag_q, tag_d;
  logic [1:0][NUM_SETS-1:0][LINE_WIDTH-1:0] data_q, data_d;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [WSL_W-1:0] wsel;
  logic             hit0, hit1, hit, hit_way, vict;

  // Merge right-aligned write data into an existing word per access size.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    case (sz)
      2'b01:   r[{off, 3'b000} +: 8]     = wd[7:0];
      2'b10:   r[{off[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // Address decode and tag compare against the latched request.
  always_comb begin
    idx     = req_q.addr[OFF_W +: IDX_W];
    tag     = req_q.addr[ADDR_WIDTH-1 -: TAG_W];
    wsel    = req_q.addr[OFF_W-1 -: WSL_W];
    hit0    = valid_q[0][idx] && (tag_q[0][idx] == tag);
    hit1    = valid_q[1][idx] && (tag_q[1][idx] == tag);
    hit     = hit0 | hit1;
    hit_way = ~hit0;
    // Invalid way first (way0 preferred), otherwise the LRU way.
    vict    = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  // Refill re-lookups are excluded so each request counts exactly once.
  always_comb begin
    hit_cnt_d  = hit_cnt_q  + 32'((state_q == LOOKUP) && hit && !refill_q);
    miss_cnt_d = miss_cnt_q + 32'((state_q == LOOKUP) && !hit);
  end
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

  // Next-state, storage updates and state-decoded memory-side outputs.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    victim_d = victim_q;
    refill_d = refill_q;
    rdata_d  = rdata_q;
    valid_d  = valid_q;
    dirty_d  = dirty_q;
    lru_d    = lru_q;
    tag_d    = tag_q;
    data_d   = data_q;
    op_finished       = 1'b0;
    write_back_enable = 1'b0;
    write_back_data   = '0;
    load_enable       = 1'b0;
    mem_addr          = '0;
    case (state_q)
      IDLE: begin
        if (read_enable || write_enable) begin
          req_d    = '{addr: addr, wdata: wdata, size: byte_size, wr: write_enable};
          refill_d = 1'b0;
          state_d  = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          if (req_q.wr) begin
            data_d[hit_way][idx][{wsel, 5'b00000} +: 32] =
              merge(data_q[hit_way][idx][{wsel, 5'b00000} +: 32],
                    req_q.wdata, req_q.size, req_q.addr[1:0]);
            dirty_d[hit_way][idx] = 1'b1;
          end else begin
            rdata_d = data_q[hit_way][idx][{wsel, 5'b00000} +: 32];
          end
          lru_d[idx] = ~hit_way;
          state_d    = DONE;
        end else begin
          victim_d = vict;
          state_d  = (valid_q[vict][idx] && dirty_q[vict][idx]) ? WRITE_BACK : LOAD;
        end
      end
      WRITE_BACK: begin
        write_back_enable = 1'b1;
        write_back_data   = data_q[victim_q][idx];
        mem_addr          = {tag_q[victim_q][idx], idx, {OFF_W{1'b0}}};
        if (write_back_finished) begin
          dirty_d[victim_q][idx] = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load_enable = 1'b1;
        mem_addr    = {req_q.addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        if (load_finished) begin
          data_d[victim_q][idx]  = ldata;
          tag_d[victim_q][idx]   = tag;
          valid_d[victim_q][idx] = 1'b1;
          dirty_d[victim_q][idx] = 1'b0;
          refill_d = 1'b1;
          state_d  = LOOKUP;
        end
      end
      DONE: begin
        op_finished = 1'b1;
        if (!read_enable && !write_enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdata = rdata_q;

  // Control state and line metadata; reset drops all lines and any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= '0;
      victim_q <= 1'b0;
      refill_q <= 1'b0;
      rdata_q  <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
      lru_q    <= '0;
`ifdef CACHE_STATS_EN
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      victim_q <= victim_d;
      refill_q <= refill_d;
      rdata_q  <= rdata_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      lru_q    <= lru_d;
`ifdef CACHE_STATS_EN
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
`endif
    end
  end

  // Tag and data arrays are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_cache.sv
// Directed bench for the two-way cache, with a bench-driven memory responder.
module tb_cache;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic         read_enable = 1'b0, write_enable = 1'b0;
  logic [31:0]  addr = '0, wdata = '0;
  logic [1:0]   byte_size = '0;
  logic [31:0]  rdata, mem_addr;
  logic         op_finished, write_back_enable, load_enable;
  logic [127:0] write_back_data, ldata = '0;
  logic         write_back_finished = 1'b0, load_finished = 1'b0;

  int checks = 0, errors = 0;
  int cycles;
  logic saw_wb, saw_ld, timed_out;
  logic [31:0] wb_addr, ld_addr, wb_w0;

  cache dut (
    .clk(clk), .rst_n(rst_n), .read_enable(read_enable), .write_enable(write_enable),
    .addr(addr), .byte_size(byte_size), .wdata(wdata), .rdata(rdata),
    .op_finished(op_finished), .write_back_enable(write_back_enable),
    .write_back_data(write_back_data), .write_back_finished(write_back_finished),
    .load_enable(load_enable), .mem_addr(mem_addr), .ldata(ldata),
    .load_finished(load_finished)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request and act as memory until op_finished; enables stay high.
  task automatic run_op(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] wd, input logic [127:0] ld);
    @(negedge clk);
    write_enable = wr; read_enable = ~wr; addr = a; byte_size = sz; wdata = wd; ldata = ld;
    cycles = 0; saw_wb = 0; saw_ld = 0; timed_out = 0;
    wb_addr = '0; ld_addr = '0; wb_w0 = '0;
    forever begin
      @(posedge clk); #1;
      cycles++;
      write_back_finished = 1'b0; load_finished = 1'b0;
      if (write_back_enable) begin
        saw_wb = 1; wb_addr = mem_addr; wb_w0 = write_back_data[31:0];
        write_back_finished = 1'b1;
      end
      if (load_enable) begin
        saw_ld = 1; ld_addr = mem_addr; load_finished = 1'b1;
      end
      if (op_finished) break;
      if (cycles >= 40) begin timed_out = 1; break; end
    end
    write_back_finished = 1'b0; load_finished = 1'b0;
    chk("op_timeout", timed_out, 0);
  endtask

  task automatic release_op();
    @(negedge clk);
    read_enable = 0; write_enable = 0;
    @(posedge clk); #1;
    chk("op_fin_clear", op_finished, 0);
  endtask

  // Read expecting a hit: fixed latency, no memory traffic.
  task automatic read_hit(input logic [31:0] a, input logic [31:0] exp);
    run_op(0, a, 2'b00, 0, '0);
    chk($sformatf("rd_%0h", a), rdata, exp);
    chk($sformatf("hit_lat_%0h", a), cycles, 2);
    chk($sformatf("hit_noload_%0h", a), saw_ld | saw_wb, 0);
    release_op();
  endtask

  initial begin
    #12;
    chk("rst_opfin", op_finished, 0);
    chk("rst_ld", load_enable, 0);
    chk("rst_wb", write_back_enable, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_maddr", mem_addr, 0);
    @(negedge clk); rst_n = 1;

    // Write-allocate miss into empty set 0.
    run_op(1, 32'h0, 2'b00, 32'h1234, '0);
    chk("w0_load", saw_ld, 1);
    chk("w0_ldaddr", ld_addr, 32'h0);
    chk("w0_nowb", saw_wb, 0);
    chk("w0_lat", cycles, 4);
    release_op();
    read_hit(32'h0, 32'h0000_1234);

    // Line fill word order.
    run_op(0, 32'h10, 2'b00, 0, 128'h0000_1010_0000_1C1C_0000_1414_0000_1111);
    chk("f_rd", rdata, 32'h1111);
    chk("f_ldaddr", ld_addr, 32'h10);
    release_op();
    read_hit(32'h14, 32'h1414);
    read_hit(32'h18, 32'h1C1C);
    read_hit(32'h1C, 32'h1010);

    // Second way of set 0.
    run_op(0, 32'hA000_0000, 2'b00, 0, 128'hAAAA);
    chk("a_rd", rdata, 32'hAAAA);
    chk("a_ldaddr", ld_addr, 32'hA000_0000);
    chk("a_nowb", saw_wb, 0);
    release_op();
    read_hit(32'h0, 32'h1234);
    read_hit(32'hA000_0000, 32'hAAAA);   // leaves dirty 0x0 as LRU

    // Dirty eviction of 0x0.
    run_op(0, 32'hB000_0000, 2'b00, 0, 128'hB00B);
    chk("b_wb", saw_wb, 1);
    chk("b_wbaddr", wb_addr, 32'h0);
    chk("b_wbdata", wb_w0, 32'h1234);
    chk("b_ldaddr", ld_addr, 32'hB000_0000);
    chk("b_rd", rdata, 32'hB00B);
    chk("b_lat", cycles, 5);
    release_op();

    // Clean victim (0xA000_0000) evicts with no write-back.
    run_op(0, 32'hC000_0000, 2'b00, 0, 128'hC0C0);
    chk("c_nowb", saw_wb, 0);
    chk("c_ldaddr", ld_addr, 32'hC000_0000);
    chk("c_rd", rdata, 32'hC0C0);
    release_op();

    // Sub-word writes and word write ignoring the low offset.
    run_op(1, 32'h11, 2'b01, 32'hFFAB, '0);
    chk("bw_hit", saw_ld, 0);
    release_op();
    read_hit(32'h10, 32'h0000_AB11);
    run_op(1, 32'h13, 2'b10, 32'hBEEF, '0);
    release_op();
    read_hit(32'h10, 32'hBEEF_AB11);
    run_op(1, 32'h17, 2'b11, 32'hDEAD_BEEF, '0);
    release_op();
    read_hit(32'h14, 32'hDEAD_BEEF);

    // Held enables: a single completion, state stays in DONE.
    run_op(0, 32'h1C, 2'b00, 0, '0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("hold_opfin", op_finished, 1);
      chk("hold_rdata", rdata, 32'h1010);
      chk("hold_noload", load_enable, 0);
    end
    release_op();

    // Reset during LOAD.
    @(negedge clk);
    read_enable = 1; addr = 32'h20; ldata = 128'h2222;
    cycles = 0;
    do begin @(posedge clk); #1; cycles++; end while (!load_enable && cycles < 20);
    chk("rl_reached", load_enable, 1);
    rst_n = 0; #1;
    chk("rl_ld", load_enable, 0);
    chk("rl_opfin", op_finished, 0);
    chk("rl_maddr", mem_addr, 0);
    chk("rl_rdata", rdata, 0);
    @(negedge clk); read_enable = 0; rst_n = 1;
    run_op(0, 32'h0, 2'b00, 0, 128'h5555);
    chk("rl_remiss", saw_ld, 1);
    chk("rl_rd", rdata, 32'h5555);
    release_op();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
